board_loader: RTL and testbench
===============================

Name: board_loader

Overview:
- Upstream of the move generator (all_moves) and the attack/check block (vchess).
- Receives a serialized position as a byte stream over a valid/ready handshake and assembles it into a staging register.
- Validates the frame, then publishes board, side-to-move, castle mask and en-passant column with a one-cycle board_valid pulse.
- Holds the published outputs stable until the consumer releases it, so downstream search and display see a frozen position.

Parameters:
PIECE_WIDTH, `PIECE_BITS, bits per square code
SIDE_WIDTH, PIECE_WIDTH*8, bits per rank
BOARD_WIDTH, PIECE_WIDTH*64, bits per board

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  block accepts a byte this cycle
abort  input  1  synchronous pulse: discard partial frame
release  input  1  synchronous pulse: consumer done, leave HOLD
board  output  BOARD_WIDTH  published board; square s = row*8+col at [s*PIECE_WIDTH +: PIECE_WIDTH], row 0 = white back rank
white_to_move  output  1  published side to move
castle_mask  output  4  published castle rights
en_passant_col  output  4  published e.p. column; 8 = none
board_valid  output  1  one-cycle pulse: new position published
load_error  output  1  one-cycle pulse: frame rejected
busy  output  1  high from first accepted byte until return to RX_SQ

Behaviour:
- Frame format is 66 bytes:
  - Bytes 0..63: square codes for squares 0..63. Low PIECE_WIDTH bits are the code; bits [7:PIECE_WIDTH] must be 0.
  - Byte 64: flags. Bit0 = white_to_move, bits[4:1] = castle_mask, bits[7:5] must be 0.
  - Byte 65: en-passant. Bits[3:0] must be 0..8, bits[7:4] must be 0.
- Byte transfer occurs on a cycle where in_valid && in_ready.
- in_ready = 1 in RX_SQ, RX_FLAGS, RX_EP, and only when abort = 0; it is 0 in all other states.
- States:
  - RX_SQ: 6-bit square counter sq. Each accepted byte writes staging[sq] and increments sq. At sq = 63 the transfer goes to RX_FLAGS.
  - RX_FLAGS: one accepted byte goes to RX_EP.
  - RX_EP: one accepted byte goes to CHECK.
  - CHECK: one cycle. Error if any format bit was violated, or white king count != 1, or black king count != 1.
    - Counts use `WHITE_KING/`BLACK_KING and are accumulated per byte with 2-bit saturating counters.
    - Error: pulse load_error for 1 cycle, leave outputs unchanged, go to RX_SQ.
    - Pass: go to EMIT.
  - EMIT: copy staging into board/white_to_move/castle_mask/en_passant_col; board_valid = 1 this cycle only; go to HOLD.
  - HOLD: outputs frozen. release or abort goes to RX_SQ.
- Latency: last byte accepted at cycle N → CHECK at N+1 → board_valid and new outputs visible at N+2.
- Staging is separate from the published registers. The published values change only in EMIT, never during reception.
- On returning to RX_SQ: sq, king counters and error flag clear.
- abort in RX_* states:
  - Takes priority over a concurrent byte; that byte is not consumed.
  - Returns to RX_SQ with sq = 0.
  - No load_error pulse; outputs unchanged.
- abort in CHECK or EMIT is ignored (the frame completes). release outside HOLD is ignored.
- in_valid gaps in the middle of a frame are allowed; no timeout.
- Reset (asserted at any time, including mid-frame or during HOLD):
  - Published registers: board all `EMPTY_POSN, white_to_move 1, castle_mask 0, en_passant_col 4'b1000.
  - board_valid 0, load_error 0, busy 0, in_ready 0.
  - State RX_SQ, sq 0; staging cleared to `EMPTY_POSN.
  - In the first cycle after deassertion, in_ready = 1.

Test Plan:
1. Send 66 bytes with `WHITE_KING at sq 0, `WHITE_ROOK at 15, `BLACK_PAWN at 12, `BLACK_QUEN at 62, `BLACK_KING at 57, all others `EMPTY_POSN; flags 0x1F; ep 0x08 → board_valid pulses exactly once, 2 cycles after the last byte. Required outputs: board matches, white_to_move = 1, castle_mask = 4'b1111, en_passant_col = 8, in_ready = 0 until release.
2. Same frame with no black king → load_error pulses once; board_valid stays 0; outputs keep the reset values; in_ready = 1 on the next cycle.
3. Square byte 0x80 at sq 5, or ep byte 0x09 → load_error; no publish.
4. Abort after 30 bytes, with in_valid high on the abort cycle, then send a full valid frame → exactly 66 bytes consumed after the abort; one board_valid; board reflects only the second frame.
5. During HOLD, drive in_valid for 10 cycles → in_ready stays 0 and outputs are unchanged. Pulse release, then send a second frame → the outputs update only at its EMIT.
6. Assert reset after 40 bytes → all outputs return to reset values; a subsequent full frame publishes correctly.
7. Random in_valid gaps (≈50% duty) on the valid frame from scenario 1 → identical result to scenario 1.

Source files
------------

// File: rtl/board_loader.sv
// board_loader: receives a 66-byte serialized chess position over valid/ready,
// validates it, and publishes a frozen snapshot for move generation and check logic.
`ifndef PIECE_BITS
`define PIECE_BITS 4
`endif
`ifndef EMPTY_POSN
`define EMPTY_POSN 4'd0
`endif
`ifndef WHITE_PAWN
`define WHITE_PAWN 4'd1
`endif
`ifndef WHITE_KNIT
`define WHITE_KNIT 4'd2
`endif
`ifndef WHITE_BISH
`define WHITE_BISH 4'd3
`endif
`ifndef WHITE_ROOK
`define WHITE_ROOK 4'd4
`endif
`ifndef WHITE_QUEN
`define WHITE_QUEN 4'd5
`endif
`ifndef WHITE_KING
`define WHITE_KING 4'd6
`endif
`ifndef BLACK_PAWN
`define BLACK_PAWN 4'd9
`endif
`ifndef BLACK_KNIT
`define BLACK_KNIT 4'd10
`endif
`ifndef BLACK_BISH
`define BLACK_BISH 4'd11
`endif
`ifndef BLACK_ROOK
`define BLACK_ROOK 4'd12
`endif
`ifndef BLACK_QUEN
`define BLACK_QUEN 4'd13
`endif
`ifndef BLACK_KING
`define BLACK_KING 4'd14
`endif

module board_loader #(
   parameter int PIECE_WIDTH = `PIECE_BITS,
   parameter int SIDE_WIDTH  = PIECE_WIDTH * 8,
   parameter int BOARD_WIDTH = PIECE_WIDTH * 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [7:0]             in_data,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   abort,
   input  logic                   release_req,
   output logic [BOARD_WIDTH-1:0] board,
   output logic                   white_to_move,
   output logic [3:0]             castle_mask,
   output logic [3:0]             en_passant_col,
   output logic                   board_valid,
   output logic                   load_error,
   output logic                   busy
);

   typedef enum logic [2:0] {
      RX_SQ    = 3'd0,
      RX_FLAGS = 3'd1,
      RX_EP    = 3'd2,
      CHECK    = 3'd3,
      EMIT     = 3'd4,
      HOLD     = 3'd5
   } state_t;

   state_t                 state_q, state_d;
   logic [5:0]             sq_q, sq_d;
   logic [1:0]             wk_cnt_q, wk_cnt_d;
   logic [1:0]             bk_cnt_q, bk_cnt_d;
   logic                   fmt_err_q, fmt_err_d;
   logic [PIECE_WIDTH-1:0] stage_q [64];
   logic [PIECE_WIDTH-1:0] stage_d [64];
   logic                   stage_wtm_q, stage_wtm_d;
   logic [3:0]             stage_castle_q, stage_castle_d;
   logic [3:0]             stage_ep_q, stage_ep_d;
   logic [BOARD_WIDTH-1:0] board_q, board_d;
   logic                   wtm_q, wtm_d;
   logic [3:0]             castle_q, castle_d;
   logic [3:0]             ep_q, ep_d;
   logic                   board_valid_q, board_valid_d;
   logic                   load_error_q, load_error_d;
   logic                   busy_q, busy_d;
   logic                   rx_state_s, accept_s, clear_s;
   logic [PIECE_WIDTH-1:0] code_s;

   function automatic logic [1:0] sat_inc(input logic [1:0] cnt, input logic hit);
      logic [1:0] res;
      if (hit && (cnt != 2'd3)) res = cnt + 2'd1;
      else                      res = cnt;
      return res;
   endfunction

   // Ready is also gated by reset so nothing is offered while the block is held in reset.
   assign rx_state_s = (state_q == RX_SQ) || (state_q == RX_FLAGS) || (state_q == RX_EP);
   assign in_ready   = reset && !abort && rx_state_s;
   assign accept_s   = in_valid && in_ready;
   assign code_s     = in_data[PIECE_WIDTH-1:0];

   // Next-state, staging and publish computation
   always_comb begin
      state_d        = state_q;
      sq_d           = sq_q;
      wk_cnt_d       = wk_cnt_q;
      bk_cnt_d       = bk_cnt_q;
      fmt_err_d      = fmt_err_q;
      stage_d        = stage_q;
      stage_wtm_d    = stage_wtm_q;
      stage_castle_d = stage_castle_q;
      stage_ep_d     = stage_ep_q;
      board_d        = board_q;
      wtm_d          = wtm_q;
      castle_d       = castle_q;
      ep_d           = ep_q;
      board_valid_d  = 1'b0;
      load_error_d   = 1'b0;
      clear_s        = 1'b0;
      case (state_q)
         RX_SQ: begin
            if (abort) begin
               clear_s = 1'b1;
            end else if (accept_s) begin
               stage_d[sq_q] = code_s;
               fmt_err_d     = fmt_err_q | ((in_data >> PIECE_WIDTH) != 8'd0);
               wk_cnt_d      = sat_inc(wk_cnt_q, code_s == `WHITE_KING);
               bk_cnt_d      = sat_inc(bk_cnt_q, code_s == `BLACK_KING);
               sq_d          = sq_q + 6'd1;
               state_d       = (sq_q == 6'd63) ? RX_FLAGS : RX_SQ;
            end else begin
               state_d = RX_SQ;
            end
         end
         RX_FLAGS: begin
            if (abort) begin
               state_d = RX_SQ;
               clear_s = 1'b1;
            end else if (accept_s) begin
               stage_wtm_d    = in_data[0];
               stage_castle_d = in_data[4:1];
               fmt_err_d      = fmt_err_q | (in_data[7:5] != 3'd0);
               state_d        = RX_EP;
            end else begin
               state_d = RX_FLAGS;
            end
         end
         RX_EP: begin
            if (abort) begin
               state_d = RX_SQ;
               clear_s = 1'b1;
            end else if (accept_s) begin
               stage_ep_d = in_data[3:0];
               fmt_err_d  = fmt_err_q | (in_data[7:4] != 4'd0) | (in_data[3:0] > 4'd8);
               state_d    = CHECK;
            end else begin
               state_d = RX_EP;
            end
         end
         CHECK: begin
            // Published registers load here so they appear together with the board_valid pulse.
            if (fmt_err_q || (wk_cnt_q != 2'd1) || (bk_cnt_q != 2'd1)) begin
               load_error_d = 1'b1;
               state_d      = RX_SQ;
               clear_s      = 1'b1;
            end else begin
               for (int r = 0; r < 8; r++) begin
                  for (int c = 0; c < 8; c++) begin
                     board_d[r*SIDE_WIDTH + c*PIECE_WIDTH +: PIECE_WIDTH] = stage_q[r*8 + c];
                  end
               end
               wtm_d         = stage_wtm_q;
               castle_d      = stage_castle_q;
               ep_d          = stage_ep_q;
               board_valid_d = 1'b1;
               state_d       = EMIT;
            end
         end
         EMIT: begin
            state_d = HOLD;
         end
         HOLD: begin
            if (release_req || abort) begin
               state_d = RX_SQ;
               clear_s = 1'b1;
            end else begin
               state_d = HOLD;
            end
         end
         default: begin
            state_d = RX_SQ;
            clear_s = 1'b1;
         end
      endcase
      sq_d      = clear_s ? 6'd0 : sq_d;
      wk_cnt_d  = clear_s ? 2'd0 : wk_cnt_d;
      bk_cnt_d  = clear_s ? 2'd0 : bk_cnt_d;
      fmt_err_d = clear_s ? 1'b0 : fmt_err_d;
      busy_d    = (state_d != RX_SQ) || (sq_d != 6'd0);
   end

   // State, staging and published registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= RX_SQ;
         sq_q           <= 6'd0;
         wk_cnt_q       <= 2'd0;
         bk_cnt_q       <= 2'd0;
         fmt_err_q      <= 1'b0;
         for (int s = 0; s < 64; s++) stage_q[s] <= `EMPTY_POSN;
         stage_wtm_q    <= 1'b1;
         stage_castle_q <= 4'd0;
         stage_ep_q     <= 4'b1000;
         board_q        <= {64{`EMPTY_POSN}};
         wtm_q          <= 1'b1;
         castle_q       <= 4'd0;
         ep_q           <= 4'b1000;
         board_valid_q  <= 1'b0;
         load_error_q   <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         sq_q           <= sq_d;
         wk_cnt_q       <= wk_cnt_d;
         bk_cnt_q       <= bk_cnt_d;
         fmt_err_q      <= fmt_err_d;
         stage_q        <= stage_d;
         stage_wtm_q    <= stage_wtm_d;
         stage_castle_q <= stage_castle_d;
         stage_ep_q     <= stage_ep_d;
         board_q        <= board_d;
         wtm_q          <= wtm_d;
         castle_q       <= castle_d;
         ep_q           <= ep_d;
         board_valid_q  <= board_valid_d;
         load_error_q   <= load_error_d;
         busy_q         <= busy_d;
      end
   end

   assign board          = board_q;
   assign white_to_move  = wtm_q;
   assign castle_mask    = castle_q;
   assign en_passant_col = ep_q;
   assign board_valid    = board_valid_q;
   assign load_error     = load_error_q;
   assign busy           = busy_q;

endmodule

// File: tb/tb_board_loader.sv
// Scoreboard bench for board_loader: frames are modelled at byte level, expected
// publish/reject results are queued, and a monitor checks each DUT pulse.
`ifndef EMPTY_POSN
`define EMPTY_POSN 4'd0
`endif
`ifndef WHITE_ROOK
`define WHITE_ROOK 4'd4
`endif
`ifndef WHITE_QUEN
`define WHITE_QUEN 4'd5
`endif
`ifndef WHITE_KING
`define WHITE_KING 4'd6
`endif
`ifndef BLACK_PAWN
`define BLACK_PAWN 4'd9
`endif
`ifndef BLACK_ROOK
`define BLACK_ROOK 4'd12
`endif
`ifndef BLACK_QUEN
`define BLACK_QUEN 4'd13
`endif
`ifndef BLACK_KING
`define BLACK_KING 4'd14
`endif

module tb_board_loader;
   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [7:0]   in_data = 8'd0;
   logic         in_valid = 1'b0;
   logic         abort = 1'b0;
   logic         rel = 1'b0;
   logic         in_ready, white_to_move, board_valid, load_error, busy;
   logic [255:0] board;
   logic [3:0]   castle_mask, en_passant_col;

   always #5 clk = ~clk;

   board_loader dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .abort(abort), .release_req(rel), .board(board), .white_to_move(white_to_move),
      .castle_mask(castle_mask), .en_passant_col(en_passant_col), .board_valid(board_valid),
      .load_error(load_error), .busy(busy)
   );

   typedef struct {
      bit           err;
      logic [255:0] board;
      bit           wtm;
      logic [3:0]   castle;
      logic [3:0]   ep;
      int           cyc;
   } exp_t;

   exp_t         exp_q[$];
   exp_t         mon_e;
   logic [7:0]   frame [66];
   logic [255:0] pub_board;
   bit           pub_wtm;
   logic [3:0]   pub_castle, pub_ep;
   bit           last_err;
   int pass_cnt = 0, chk_cnt = 0, cyc = 0, acc_cnt = 0, valid_cnt = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h, want %0h", name, act, exp);
   endtask

   task automatic model_reset();
      pub_board  = '0;
      pub_wtm    = 1'b1;
      pub_castle = 4'd0;
      pub_ep     = 4'd8;
   endtask

   // Reference: a frame is accepted only if every reserved bit is zero, ep <= 8 and each side has one king.
   function automatic exp_t model_frame(input int acc);
      exp_t e;
      int   wk = 0, bk = 0;
      bit   bad = 1'b0;
      for (int s = 0; s < 64; s++) begin
         if (frame[s][7:4] != 4'd0) bad = 1'b1;
         if (frame[s][3:0] == `WHITE_KING) wk++;
         if (frame[s][3:0] == `BLACK_KING) bk++;
         e.board[s*4 +: 4] = frame[s][3:0];
      end
      if (frame[64][7:5] != 3'd0) bad = 1'b1;
      if (frame[65][7:4] != 4'd0 || frame[65][3:0] > 4'd8) bad = 1'b1;
      e.err    = bad || (wk != 1) || (bk != 1);
      e.wtm    = frame[64][0];
      e.castle = frame[64][4:1];
      e.ep     = frame[65][3:0];
      e.cyc    = acc;
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (reset && in_valid && in_ready) acc_cnt++;

   // Monitor: every board_valid / load_error pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (reset && (board_valid || load_error)) begin
         if (board_valid) valid_cnt++;
         if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL spurious_pulse: board_valid=%0b load_error=%0b, want no pulse", board_valid, load_error);
         end else begin
            mon_e = exp_q.pop_front();
            chk("latency", cyc, mon_e.cyc + 2);
            chk("board_valid", board_valid, !mon_e.err);
            chk("load_error", load_error, mon_e.err);
            if (!mon_e.err) begin
               pub_board  = mon_e.board;
               pub_wtm    = mon_e.wtm;
               pub_castle = mon_e.castle;
               pub_ep     = mon_e.ep;
            end else begin
               chk("ready_after_error", in_ready, 1'b1);
            end
            chk("board", board, pub_board);
            chk("white_to_move", white_to_move, pub_wtm);
            chk("castle_mask", castle_mask, pub_castle);
            chk("en_passant_col", en_passant_col, pub_ep);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps, output int acc_at);
      int waited = 0;
      if (gaps && $urandom_range(0, 1) == 1) begin
         in_valid = 1'b0;
         tick();
      end
      in_data  = b;
      in_valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 50) begin
            chk_cnt++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, want high", waited);
            break;
         end
         tick();
      end
      acc_at = cyc;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input bit gaps);
      int   acc;
      exp_t e;
      for (int i = 0; i < 66; i++) send_byte(frame[i], gaps, acc);
      e = model_frame(acc);
      last_err = e.err;
      exp_q.push_back(e);
   endtask

   task automatic wait_done();
      repeat (4) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
   endtask

   task automatic pulse_release();
      rel = 1'b1;
      tick();
      rel = 1'b0;
   endtask

   task automatic build_base();
      for (int s = 0; s < 66; s++) frame[s] = 8'd0;
      frame[0]  = {4'd0, `WHITE_KING};
      frame[15] = {4'd0, `WHITE_ROOK};
      frame[12] = {4'd0, `BLACK_PAWN};
      frame[62] = {4'd0, `BLACK_QUEN};
      frame[57] = {4'd0, `BLACK_KING};
      frame[64] = 8'h1F;
      frame[65] = 8'h08;
   endtask

   task automatic build_random();
      int n, idx;
      logic [3:0] code;
      for (int s = 0; s < 64; s++) begin
         code = 4'($urandom_range(1, 5));
         if ($urandom_range(0, 1) == 1) code = code + 4'd8;
         frame[s] = ($urandom_range(0, 1) == 1) ? 8'd0 : {4'd0, code};
      end
      n = ($urandom_range(0, 9) < 8) ? 1 : 2 * $urandom_range(0, 1);
      for (int k = 0; k < n; k++) frame[$urandom_range(0, 63)] = {4'd0, `WHITE_KING};
      n = ($urandom_range(0, 9) < 8) ? 1 : 2 * $urandom_range(0, 1);
      for (int k = 0; k < n; k++) frame[$urandom_range(0, 63)] = {4'd0, `BLACK_KING};
      if ($urandom_range(0, 19) == 0) begin
         idx = $urandom_range(0, 63);
         frame[idx] = frame[idx] | (8'h10 << $urandom_range(0, 3));
      end
      frame[64] = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
      frame[65] = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(0, 8));
   endtask

   task automatic chk_reset_outputs();
      chk("rst_board", board, 256'd0);
      chk("rst_wtm", white_to_move, 1'b1);
      chk("rst_castle", castle_mask, 4'd0);
      chk("rst_ep", en_passant_col, 4'd8);
      chk("rst_valid", board_valid, 1'b0);
      chk("rst_error", load_error, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_ready", in_ready, 1'b0);
   endtask

   initial begin
      int a0, v0, acc;
      model_reset();
      repeat (3) tick();
      @(negedge clk);
      chk_reset_outputs();
      @(posedge clk);
      #1 reset = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", in_ready, 1'b1);
      tick();

      // Valid frame, then HOLD behaviour and release
      build_base();
      send_frame(1'b0);
      wait_done();
      chk("hold_ready", in_ready, 1'b0);
      chk("hold_busy", busy, 1'b1);
      pulse_release();
      chk("released_ready", in_ready, 1'b1);
      chk("released_busy", busy, 1'b0);

      // Rejected frames: missing black king, bad square byte, bad ep byte
      build_base(); frame[57] = 8'd0;  send_frame(1'b0); wait_done();
      build_base(); frame[5]  = 8'h80; send_frame(1'b0); wait_done();
      build_base(); frame[65] = 8'h09; send_frame(1'b0); wait_done();

      // Abort after 30 bytes with a byte offered on the abort cycle
      for (int i = 0; i < 30; i++) send_byte(8'h01, 1'b0, acc);
      abort = 1'b1; in_valid = 1'b1; in_data = {4'd0, `WHITE_KING};
      @(negedge clk);
      chk("abort_ready", in_ready, 1'b0);
      tick();
      abort = 1'b0; in_valid = 1'b0;
      a0 = acc_cnt; v0 = valid_cnt;
      build_base(); frame[20] = {4'd0, `WHITE_QUEN};
      send_frame(1'b0);
      wait_done();
      chk("abort_bytes", acc_cnt - a0, 66);
      chk("abort_pulses", valid_cnt - v0, 1);

      // HOLD ignores traffic; second frame publishes only at its EMIT
      a0 = acc_cnt;
      in_valid = 1'b1; in_data = 8'h01;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("hold_ready_traffic", in_ready, 1'b0);
         tick();
      end
      in_valid = 1'b0;
      chk("hold_no_accept", acc_cnt - a0, 0);
      chk("hold_board", board, pub_board);
      pulse_release();
      build_base(); frame[30] = {4'd0, `BLACK_ROOK}; frame[64] = 8'h02; frame[65] = 8'h03;
      send_frame(1'b0);
      chk("no_early_publish", board, pub_board);
      chk("no_early_ep", en_passant_col, pub_ep);
      wait_done();
      pulse_release();

      // Reset mid-frame
      build_base(); frame[33] = {4'd0, `BLACK_PAWN};
      for (int i = 0; i < 40; i++) send_byte(frame[i], 1'b0, acc);
      reset = 1'b0;
      @(negedge clk);
      chk_reset_outputs();
      model_reset();
      exp_q.delete();
      tick();
      reset = 1'b1;
      tick();
      send_frame(1'b0);
      wait_done();
      pulse_release();

      // Scenario-1 frame with random valid gaps
      build_base();
      send_frame(1'b1);
      wait_done();
      pulse_release();

      // Random frames
      for (int r = 0; r < 20; r++) begin
         build_random();
         send_frame($urandom_range(0, 1) == 1);
         wait_done();
         if (!last_err) pulse_release();
      end

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
